// File: rtl/dma_pkg.sv
// Shared constants for the DMA channel bank: register-select encoding and
// default geometry.
package dma_pkg;

  localparam int unsigned NUM_CH_DEFAULT = 4;
  localparam int unsigned REG_W_DEFAULT  = 16;

  localparam logic REG_ADDR  = 1'b0;
  localparam logic REG_COUNT = 1'b1;

endpackage

// File: rtl/dma_channel_regs.sv
// One DMA channel: base/current address and word-count registers, byte-wise
// CPU loading, and per-transfer step with terminal-count auto-reload.
module dma_channel_regs
  import dma_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEFAULT,
  parameter int unsigned BP_W  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic             reg_sel_i,
  input  logic [BP_W-1:0]  bp_i,
  input  logic [7:0]       wr_data_i,
  input  logic             step_i,
  input  logic             addr_dec_i,
  input  logic             auto_init_i,
  output logic [REG_W-1:0] cur_addr_o,
  output logic [REG_W-1:0] cur_count_o,
  output logic             tc_o
);

  logic [REG_W-1:0] base_addr_q, base_addr_d;
  logic [REG_W-1:0] base_count_q, base_count_d;
  logic [REG_W-1:0] cur_addr_q, cur_addr_d;
  logic [REG_W-1:0] cur_count_q, cur_count_d;
  logic [BP_W+2:0]  lsb;
  logic             step_ok;

  // A CPU write to this channel discards a coincident transfer step entirely.
  assign step_ok = step_i & ~wr_en_i;
  assign tc_o    = step_ok && (cur_count_q == '0);
  assign lsb     = {bp_i, 3'b000};

  always_comb begin
    base_addr_d  = base_addr_q;
    base_count_d = base_count_q;
    cur_addr_d   = cur_addr_q;
    cur_count_d  = cur_count_q;

    if (step_ok) begin
      if (tc_o && auto_init_i) begin
        cur_addr_d  = base_addr_q;
        cur_count_d = base_count_q;
      end else begin
        cur_addr_d  = addr_dec_i ? cur_addr_q - 1'b1 : cur_addr_q + 1'b1;
        cur_count_d = cur_count_q - 1'b1;
      end
    end

    if (wr_en_i) begin
      if (reg_sel_i == REG_COUNT) begin
        base_count_d[lsb +: 8] = wr_data_i;
        cur_count_d[lsb +: 8]  = wr_data_i;
      end else begin
        base_addr_d[lsb +: 8] = wr_data_i;
        cur_addr_d[lsb +: 8]  = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_addr_q  <= '0;
      base_count_q <= '0;
      cur_addr_q   <= '0;
      cur_count_q  <= '0;
    end else begin
      base_addr_q  <= base_addr_d;
      base_count_q <= base_count_d;
      cur_addr_q   <= cur_addr_d;
      cur_count_q  <= cur_count_d;
    end
  end

  assign cur_addr_o  = cur_addr_q;
  assign cur_count_o = cur_count_q;

endmodule

// File: rtl/dma_channel_bank.sv
// Bank of DMA channels behind an 8-bit CPU port with a shared byte pointer,
// sticky terminal-count flags and a one-cycle terminal-count pulse.
module dma_channel_bank
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEFAULT,
  parameter int unsigned REG_W  = REG_W_DEFAULT,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned NBYTES = REG_W / 8,
  localparam int unsigned BP_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              master_clear_i,
  input  logic              cpu_write_i,
  input  logic              cpu_read_i,
  input  logic              reg_sel_i,
  input  logic [CH_W-1:0]   ch_sel_i,
  input  logic [7:0]        wr_data_i,
  output logic [7:0]        rd_data_o,
  input  logic              clear_ff_i,
  input  logic [NUM_CH-1:0] addr_dec_i,
  input  logic [NUM_CH-1:0] auto_init_i,
  input  logic              xfer_step_i,
  input  logic [CH_W-1:0]   active_ch_i,
  output logic [REG_W-1:0]  address_o,
  input  logic              status_read_i,
  output logic [NUM_CH-1:0] terminal_count_o,
  output logic              tc_pulse_o
);

  logic              clr;
  logic [BP_W-1:0]   bp_q, bp_d;
  logic [REG_W-1:0]  cur_addr  [NUM_CH];
  logic [REG_W-1:0]  cur_count [NUM_CH];
  logic [NUM_CH-1:0] tc_set;
  logic [NUM_CH-1:0] tc_q;
  logic              tc_pulse_q;
  logic [REG_W-1:0]  sel_reg;

  assign clr = rst_i | master_clear_i;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dma_channel_regs #(
      .REG_W (REG_W),
      .BP_W  (BP_W)
    ) u_regs (
      .clk_i       (clk_i),
      .rst_i       (clr),
      .wr_en_i     (cpu_write_i && (ch_sel_i == CH_W'(i))),
      .reg_sel_i   (reg_sel_i),
      .bp_i        (bp_q),
      .wr_data_i   (wr_data_i),
      .step_i      (xfer_step_i && (active_ch_i == CH_W'(i))),
      .addr_dec_i  (addr_dec_i[i]),
      .auto_init_i (auto_init_i[i]),
      .cur_addr_o  (cur_addr[i]),
      .cur_count_o (cur_count[i]),
      .tc_o        (tc_set[i])
    );
  end

  always_comb begin
    bp_d = bp_q;
    if (cpu_write_i || cpu_read_i) begin
      bp_d = (bp_q == BP_W'(NBYTES - 1)) ? '0 : bp_q + 1'b1;
    end
    if (clear_ff_i) begin
      bp_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      bp_q       <= '0;
      tc_q       <= '0;
      tc_pulse_q <= 1'b0;
    end else begin
      bp_q       <= bp_d;
      // A new terminal count survives a coincident status read.
      tc_q       <= (status_read_i ? '0 : tc_q) | tc_set;
      tc_pulse_q <= |tc_set;
    end
  end

  always_comb begin
    sel_reg   = (reg_sel_i == REG_COUNT) ? cur_count[ch_sel_i] : cur_addr[ch_sel_i];
    rd_data_o = cpu_read_i ? sel_reg[{bp_q, 3'b000} +: 8] : 8'h00;
  end

  assign address_o        = cur_addr[active_ch_i];
  assign terminal_count_o = tc_q;
  assign tc_pulse_o       = tc_pulse_q;

endmodule

// File: tb/tb_dma_channel_bank.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// a randomized run against a behavioural model (16-bit and 32-bit instances).
module tb_dma_channel_bank;

  logic        clk;
  logic        rst;
  logic        master_clear;
  logic        cpu_write;
  logic        cpu_read;
  logic        reg_sel;
  logic [1:0]  ch_sel;
  logic [7:0]  wr_data;
  logic        clear_ff;
  logic [3:0]  addr_dec;
  logic [3:0]  auto_init;
  logic        xfer_step;
  logic [1:0]  active_ch;
  logic        status_read;

  logic [7:0]  rd16, rd32;
  logic [15:0] addr16;
  logic [31:0] addr32;
  logic [3:0]  tc16, tc32;
  logic        pulse16, pulse32;

  int n_total = 0;
  int n_pass  = 0;

  dma_channel_bank #(.NUM_CH(4), .REG_W(16)) dut16 (
    .clk_i            (clk),
    .rst_i            (rst),
    .master_clear_i   (master_clear),
    .cpu_write_i      (cpu_write),
    .cpu_read_i       (cpu_read),
    .reg_sel_i        (reg_sel),
    .ch_sel_i         (ch_sel),
    .wr_data_i        (wr_data),
    .rd_data_o        (rd16),
    .clear_ff_i       (clear_ff),
    .addr_dec_i       (addr_dec),
    .auto_init_i      (auto_init),
    .xfer_step_i      (xfer_step),
    .active_ch_i      (active_ch),
    .address_o        (addr16),
    .status_read_i    (status_read),
    .terminal_count_o (tc16),
    .tc_pulse_o       (pulse16)
  );

  dma_channel_bank #(.NUM_CH(4), .REG_W(32)) dut32 (
    .clk_i            (clk),
    .rst_i            (rst),
    .master_clear_i   (master_clear),
    .cpu_write_i      (cpu_write),
    .cpu_read_i       (cpu_read),
    .reg_sel_i        (reg_sel),
    .ch_sel_i         (ch_sel),
    .wr_data_i        (wr_data),
    .rd_data_o        (rd32),
    .clear_ff_i       (clear_ff),
    .addr_dec_i       (addr_dec),
    .auto_init_i      (auto_init),
    .xfer_step_i      (xfer_step),
    .active_ch_i      (active_ch),
    .address_o        (addr32),
    .status_read_i    (status_read),
    .terminal_count_o (tc32),
    .tc_pulse_o       (pulse32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cff, wr, rd, sel;
    logic [1:0]  ch;
    logic [7:0]  data;
    logic        step;
    logic [1:0]  ach;
    logic [3:0]  dec, ai;
    logic        sr;
    logic [15:0] eaddr;
    logic [7:0]  erd;
    logic [3:0]  etc;
    logic        epulse;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic cff, logic wr, logic rd, logic sel, logic [1:0] ch,
                              logic [7:0] data, logic step, logic [1:0] ach, logic [3:0] dec,
                              logic [3:0] ai, logic sr, logic [15:0] eaddr, logic [7:0] erd,
                              logic [3:0] etc, logic epulse);
    vec_t v;
    v.cff = cff; v.wr = wr; v.rd = rd; v.sel = sel; v.ch = ch; v.data = data;
    v.step = step; v.ach = ach; v.dec = dec; v.ai = ai; v.sr = sr;
    v.eaddr = eaddr; v.erd = erd; v.etc = etc; v.epulse = epulse;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; master_clear = 0; cpu_write = 0; cpu_read = 0; reg_sel = 0; ch_sel = 0;
    wr_data = 0; clear_ff = 0; xfer_step = 0; status_read = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic cpu_wr(input logic [1:0] ch, input logic sel, input logic [7:0] d);
    idle();
    cpu_write = 1; ch_sel = ch; reg_sel = sel; wr_data = d;
    tick();
    cpu_write = 0;
  endtask

  task automatic cpu_rd(input logic [1:0] ch, input logic sel, output logic [7:0] d16,
                        output logic [7:0] d32);
    idle();
    cpu_read = 1; ch_sel = ch; reg_sel = sel;
    #1;
    d16 = rd16;
    d32 = rd32;
    tick();
    cpu_read = 0;
  endtask

  task automatic step_ch(input logic [1:0] ch);
    idle();
    xfer_step = 1; active_ch = ch;
    tick();
    xfer_step = 0;
  endtask

  // Behavioural model of the 16-bit instance: index [0]=address, [1]=count.
  logic [15:0] m_base [2][4];
  logic [15:0] m_cur  [2][4];
  int          m_bp;
  logic [3:0]  m_tc;
  logic        m_pulse;

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 4; c++) begin
        m_base[s][c] = 0;
        m_cur[s][c]  = 0;
      end
    m_bp = 0; m_tc = 0; m_pulse = 0;
  endtask

  function automatic logic [15:0] put_byte(logic [15:0] v, int b, logic [7:0] d);
    logic [15:0] dw;
    logic [15:0] mask;
    dw   = {8'h00, d} << (8 * b);
    mask = 16'h00FF << (8 * b);
    return (v & ~mask) | dw;
  endfunction

  task automatic model_edge();
    logic tcn;
    int   sel_i, ch_i, ach_i;
    sel_i = reg_sel; ch_i = ch_sel; ach_i = active_ch;
    tcn = 0;
    if (rst || master_clear) begin
      model_clear();
      return;
    end
    if (xfer_step && !(cpu_write && ch_sel == active_ch)) begin
      tcn = (m_cur[1][ach_i] == 0);
      if (tcn && auto_init[ach_i]) begin
        m_cur[0][ach_i] = m_base[0][ach_i];
        m_cur[1][ach_i] = m_base[1][ach_i];
      end else begin
        m_cur[0][ach_i] = addr_dec[ach_i] ? m_cur[0][ach_i] - 1 : m_cur[0][ach_i] + 1;
        m_cur[1][ach_i] = m_cur[1][ach_i] - 1;
      end
    end
    if (cpu_write) begin
      m_base[sel_i][ch_i] = put_byte(m_base[sel_i][ch_i], m_bp, wr_data);
      m_cur[sel_i][ch_i]  = put_byte(m_cur[sel_i][ch_i], m_bp, wr_data);
    end
    if (clear_ff) m_bp = 0;
    else if (cpu_write || cpu_read) m_bp = (m_bp + 1) % 2;
    m_tc    = (status_read ? 4'b0 : m_tc) | (tcn ? (4'b1 << ach_i) : 4'b0);
    m_pulse = tcn;
  endtask

  initial begin
    logic [7:0] d16, d32;
    logic [7:0] exp_rd;
    idle();
    addr_dec = 0; auto_init = 0; active_ch = 0;

    // Reset state
    do_reset();
    #1;
    check("reset_addr16", addr16, 16'h0000);
    check("reset_addr32", addr32, 32'h0);
    check("reset_rd16", rd16, 8'h00);
    check("reset_tc", tc16, 4'b0000);
    check("reset_pulse", pulse16, 1'b0);

    // Directed vector table
    //            cff wr rd sel ch data  stp ach dec ai  sr  addr       rd     tc       p
    tbl.push_back(mk(1, 0, 0, 0, 2, 8'h00, 0, 2, 0, 0, 0, 16'h0000, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 8'h34, 0, 2, 0, 0, 0, 16'h0000, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2, 8'h12, 0, 2, 0, 0, 0, 16'h0034, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 8'h00, 0, 2, 0, 0, 0, 16'h1234, 8'h34, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2, 8'h00, 0, 2, 0, 0, 0, 16'h1234, 8'h12, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 8'h00, 1, 2, 0, 4'b0100, 0, 16'h1234, 8'h00, 4'b0100, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2, 8'h00, 0, 2, 0, 0, 0, 16'h1234, 8'h00, 4'b0100, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 16'h0000, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 8'h02, 0, 1, 0, 0, 0, 16'h0000, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 8'h00, 0, 1, 0, 0, 0, 16'h0000, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'hFE, 0, 1, 0, 0, 0, 16'h0000, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'hFF, 0, 1, 0, 0, 0, 16'h00FE, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 0, 16'hFFFE, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 0, 16'hFFFF, 8'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 0, 16'h0000, 8'h00, 4'b0010, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 16'h0001, 8'h00, 4'b0010, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 1, 0, 0, 0, 16'h0001, 8'h00, 4'b0010, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'h00, 0, 1, 0, 0, 0, 16'h0002, 8'hFE, 4'b0010, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'h00, 0, 1, 0, 0, 0, 16'h0002, 8'hFF, 4'b0010, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 8'h55, 1, 3, 0, 0, 0, 16'h0000, 8'h00, 4'b0010, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 8'h00, 0, 3, 0, 0, 0, 16'h0055, 8'h00, 4'b0010, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 8'h66, 1, 1, 0, 0, 0, 16'h0002, 8'h00, 4'b0010, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 8'h00, 0, 3, 0, 0, 0, 16'h0066, 8'h00, 4'b0010, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 16'h0003, 8'h00, 4'b0010, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 16'h0000, 8'h00, 4'b0001, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0001, 8'h00, 4'b0001, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 4'b0001, 0, 0, 16'h0001, 8'h00, 4'b0001, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 4'b0001, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      idle();
      clear_ff = tbl[i].cff; cpu_write = tbl[i].wr; cpu_read = tbl[i].rd;
      reg_sel = tbl[i].sel; ch_sel = tbl[i].ch; wr_data = tbl[i].data;
      xfer_step = tbl[i].step; active_ch = tbl[i].ach; addr_dec = tbl[i].dec;
      auto_init = tbl[i].ai; status_read = tbl[i].sr;
      #1;
      check($sformatf("vec%0d_addr", i), addr16, tbl[i].eaddr);
      check($sformatf("vec%0d_rd", i), rd16, tbl[i].erd);
      tick();
      check($sformatf("vec%0d_tc", i), tc16, tbl[i].etc);
      check($sformatf("vec%0d_pulse", i), pulse16, tbl[i].epulse);
    end
    idle();
    addr_dec = 0; auto_init = 0;

    // Auto-initialize: base 0x0100, count 0
    do_reset();
    clear_ff = 1; tick(); clear_ff = 0;
    cpu_wr(0, 0, 8'h00);
    cpu_wr(0, 0, 8'h01);
    auto_init = 4'b0001;
    step_ch(0);
    check("ai_pulse", pulse16, 1'b1);
    check("ai_tc", tc16, 4'b0001);
    check("ai_addr", addr16, 16'h0100);
    tick();
    check("ai_pulse_one_cycle", pulse16, 1'b0);
    cpu_rd(0, 1, d16, d32);
    check("ai_count_lo", d16, 8'h00);
    cpu_rd(0, 1, d16, d32);
    check("ai_count_hi", d16, 8'h00);
    step_ch(0);
    check("ai_second_tc", pulse16, 1'b1);
    check("ai_second_addr", addr16, 16'h0100);
    auto_init = 0;

    // Reset in the middle of a two-byte write
    do_reset();
    clear_ff = 1; tick(); clear_ff = 0;
    cpu_wr(2, 0, 8'hAB);
    idle();
    rst = 1; cpu_write = 1; ch_sel = 2; wr_data = 8'hCD;
    tick();
    idle();
    active_ch = 2;
    #1;
    check("mid_rst_addr", addr16, 16'h0000);
    check("mid_rst_tc", tc16, 4'b0000);
    cpu_wr(2, 0, 8'h5A);
    check("mid_rst_bp", addr16, 16'h005A);

    // 32-bit register assembly and pointer wrap
    do_reset();
    clear_ff = 1; tick(); clear_ff = 0;
    cpu_wr(0, 0, 8'h78);
    cpu_wr(0, 0, 8'h56);
    cpu_wr(0, 0, 8'h34);
    cpu_wr(0, 0, 8'h12);
    active_ch = 0;
    #1;
    check("w32_addr", addr32, 32'h12345678);
    cpu_rd(0, 0, d16, d32);
    check("w32_bp_wrap", d32, 8'h78);

    // Master clear
    idle();
    master_clear = 1;
    tick();
    master_clear = 0;
    check("mclr_addr32", addr32, 32'h0);

    // Randomized run against the model
    do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      int op;
      idle();
      op = $urandom_range(0, 99);
      cpu_write = (op < 25);
      cpu_read  = (op >= 25 && op < 40);
      reg_sel   = 1'($urandom_range(0, 1));
      ch_sel    = 2'($urandom_range(0, 3));
      wr_data   = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      xfer_step = ($urandom_range(0, 99) < 45);
      active_ch = 2'($urandom_range(0, 3));
      addr_dec  = 4'($urandom);
      auto_init = 4'($urandom);
      clear_ff  = ($urandom_range(0, 99) < 5);
      status_read  = ($urandom_range(0, 99) < 8);
      master_clear = ($urandom_range(0, 199) == 0);
      #1;
      exp_rd = cpu_read ? 8'(m_cur[reg_sel][ch_sel] >> (8 * m_bp)) : 8'h00;
      check("rnd_addr", addr16, m_cur[0][active_ch]);
      check("rnd_rd", rd16, exp_rd);
      model_edge();
      tick();
      check("rnd_tc", tc16, m_tc);
      check("rnd_pulse", pulse16, m_pulse);
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
